// File: rtl/clint_pkg.sv
// Shared definitions for the core-local interruptor: register offsets, decode, response type.
package clint_pkg;

    // Byte offsets inside the CLINT window
    localparam logic [15:0] CLINT_MSIP        = 16'h0000;
    localparam logic [15:0] CLINT_MTIMECMP_LO = 16'h4000;
    localparam logic [15:0] CLINT_MTIMECMP_HI = 16'h4004;
    localparam logic [15:0] CLINT_MTIME_LO    = 16'hBFF8;
    localparam logic [15:0] CLINT_MTIME_HI    = 16'hBFFC;

    // All-ones compare value keeps the timer interrupt quiet out of reset
    localparam logic [63:0] CLINT_MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic [2:0] {
        RegMsip,
        RegCmpLo,
        RegCmpHi,
        RegTimeLo,
        RegTimeHi,
        RegNone
    } clint_reg_e;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } clint_rsp_t;

    // Map a byte offset to a register; misaligned or unknown offsets give RegNone
    function automatic clint_reg_e clint_decode(input logic [15:0] addr);
        clint_reg_e sel;
        sel = RegNone;
        if (addr[1:0] == 2'b00) begin
            case (addr)
                CLINT_MSIP:        sel = RegMsip;
                CLINT_MTIMECMP_LO: sel = RegCmpLo;
                CLINT_MTIMECMP_HI: sel = RegCmpHi;
                CLINT_MTIME_LO:    sel = RegTimeLo;
                CLINT_MTIME_HI:    sel = RegTimeHi;
                default:           sel = RegNone;
            endcase
        end
        return sel;
    endfunction

    // Byte-granular merge of write data into an existing 32-bit word
    function automatic logic [31:0] clint_merge(input logic [31:0] old_word,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  wstrb);
        logic [31:0] res;
        res = old_word;
        for (int b = 0; b < 4; b++) begin
            if (wstrb[b]) begin
                res[8*b +: 8] = wdata[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/clint_prescaler.sv
// Divides the core clock down to a one-cycle mtime tick every TICK_DIV cycles.
module clint_prescaler #(
    parameter int unsigned TICK_DIV = 16
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    // With TICK_DIV = 1 the terminal count is 0, so the tick is asserted every cycle
    localparam logic [15:0] LAST = 16'(TICK_DIV - 1);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    // Terminal-count detect and wrap
    always_comb begin
        tick  = (cnt_q == LAST);
        cnt_d = tick ? 16'd0 : cnt_q + 16'd1;
    end

    // Prescaler counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/clint_timer.sv
// Core-local interruptor: machine timer (mtime/mtimecmp) and software interrupt bit (msip),
// exposed as a single-outstanding bus slave, with registered pending bits for the CSR file.
module clint_timer
    import clint_pkg::*;
#(
    parameter int unsigned TICK_DIV     = 16,
    parameter logic [63:0] MTIMECMP_RST = CLINT_MTIMECMP_RST
) (
    input  logic        clk,
    input  logic        cpurst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [15:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mip_mtip,
    output logic        mip_msip,
    output logic [63:0] mtime_o
);

    logic        tick;
    logic        accept;
    logic        wr_en;
    clint_reg_e  sel;
    logic [31:0] rd_word;
    clint_rsp_t  rsp_d;
    clint_rsp_t  rsp_q;
    logic        rsp_valid_q;

    logic [63:0] mtime_q;
    logic [63:0] mtime_d;
    logic [63:0] mtimecmp_q;
    logic [63:0] mtimecmp_d;
    logic        msip_q;
    logic        msip_d;
    logic        mtip_q;
    logic        msip_pend_q;

    clint_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (cpurst_n),
        .tick  (tick)
    );

    // Handshake and address decode
    always_comb begin
        req_ready = !rsp_valid_q || rsp_ready;
        accept    = req_valid && req_ready;
        sel       = clint_decode(req_addr);
        // A zero strobe writes nothing, so it must not steal a tick either
        wr_en     = accept && req_we && (sel != RegNone) && (req_wstrb != 4'h0);
    end

    // Read mux on pre-update register values
    always_comb begin
        rd_word = 32'd0;
        case (sel)
            RegMsip:   rd_word = {31'd0, msip_q};
            RegCmpLo:  rd_word = mtimecmp_q[31:0];
            RegCmpHi:  rd_word = mtimecmp_q[63:32];
            RegTimeLo: rd_word = mtime_q[31:0];
            RegTimeHi: rd_word = mtime_q[63:32];
            default:   rd_word = 32'd0;
        endcase
    end

    // Response payload: data only for mapped reads
    always_comb begin
        rsp_d.err   = (sel == RegNone);
        rsp_d.rdata = (req_we || rsp_d.err) ? 32'd0 : rd_word;
    end

    // Register next-state: a write to either mtime half overrides the tick for the whole counter
    always_comb begin
        mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
        mtimecmp_d = mtimecmp_q;
        msip_d     = msip_q;
        if (wr_en) begin
            case (sel)
                RegMsip: begin
                    if (req_wstrb[0]) begin
                        msip_d = req_wdata[0];
                    end
                end
                RegCmpLo: begin
                    mtimecmp_d = {mtimecmp_q[63:32],
                                  clint_merge(mtimecmp_q[31:0], req_wdata, req_wstrb)};
                end
                RegCmpHi: begin
                    mtimecmp_d = {clint_merge(mtimecmp_q[63:32], req_wdata, req_wstrb),
                                  mtimecmp_q[31:0]};
                end
                RegTimeLo: begin
                    mtime_d = {mtime_q[63:32], clint_merge(mtime_q[31:0], req_wdata, req_wstrb)};
                end
                RegTimeHi: begin
                    mtime_d = {clint_merge(mtime_q[63:32], req_wdata, req_wstrb), mtime_q[31:0]};
                end
                default: ;
            endcase
        end
    end

    // Architectural timer and software-interrupt state
    always_ff @(posedge clk or negedge cpurst_n) begin
        if (!cpurst_n) begin
            mtime_q    <= 64'd0;
            mtimecmp_q <= MTIMECMP_RST;
            msip_q     <= 1'b0;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            msip_q     <= msip_d;
        end
    end

    // Registered pending bits, compared on current register values (one-cycle lag)
    always_ff @(posedge clk or negedge cpurst_n) begin
        if (!cpurst_n) begin
            mtip_q      <= 1'b0;
            msip_pend_q <= 1'b0;
        end else begin
            mtip_q      <= (mtime_q >= mtimecmp_q);
            msip_pend_q <= msip_q;
        end
    end

    // Response register: loads on accept, holds until consumed
    always_ff @(posedge clk or negedge cpurst_n) begin
        if (!cpurst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_q       <= '0;
        end else if (accept) begin
            rsp_valid_q <= 1'b1;
            rsp_q       <= rsp_d;
        end else if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_q.rdata;
    assign rsp_err   = rsp_q.err;
    assign mip_mtip  = mtip_q;
    assign mip_msip  = msip_pend_q;
    assign mtime_o   = mtime_q;

endmodule

// File: tb/tb_clint_timer.sv
// Self-checking bench for clint_timer with TICK_DIV = 4 and a response scoreboard.
module tb_clint_timer;
    import clint_pkg::*;

    logic        clk = 1'b0;
    logic        cpurst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [15:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mip_mtip;
    logic        mip_msip;
    logic [63:0] mtime_o;

    int checks = 0;
    int errors = 0;
    clint_rsp_t exp_q[$];

    clint_timer #(
        .TICK_DIV     (4),
        .MTIMECMP_RST (64'hFFFF_FFFF_FFFF_FFFF)
    ) dut (
        .clk       (clk),
        .cpurst_n  (cpurst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wstrb (req_wstrb),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .mip_mtip  (mip_mtip),
        .mip_msip  (mip_msip),
        .mtime_o   (mtime_o)
    );

    always #5 clk = ~clk;

    // Scoreboard: pop and compare every consumed response
    always @(negedge clk) begin
        if (cpurst_n && rsp_valid && rsp_ready) begin
            clint_rsp_t e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rsp: got rdata=%h err=%b, none expected",
                         rsp_rdata, rsp_err);
            end else begin
                e = exp_q.pop_front();
                if (rsp_rdata !== e.rdata || rsp_err !== e.err) begin
                    errors++;
                    $display("FAIL rsp_data: got rdata=%h err=%b, expected rdata=%h err=%b",
                             rsp_rdata, rsp_err, e.rdata, e.err);
                end
            end
        end
    end

    // One bus transaction; returns 1 time unit after the acceptance edge
    task automatic bus(input logic we, input logic [15:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wstrb, input logic [31:0] exp_rdata,
                       input logic exp_err);
        clint_rsp_t e;
        bit ok;
        ok = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_wstrb = wstrb;
        for (int i = 0; i < 20; i++) begin
            if (req_ready) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL bus_accept_timeout: addr=%h req_ready stayed 0", addr);
            req_valid = 1'b0;
            return;
        end
        e.rdata = exp_rdata;
        e.err   = exp_err;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        checks++;
        if (rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL rsp_latency: addr=%h rsp_valid=%b, expected 1 one cycle after accept",
                     addr, rsp_valid);
        end
    endtask

    task automatic test_reset();
        cpurst_n  = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 16'h0;
        req_wdata = 32'h0;
        req_wstrb = 4'h0;
        rsp_ready = 1'b1;
        #12;
        checks++;
        if ({rsp_valid, rsp_rdata, rsp_err, mip_mtip, mip_msip} !== 36'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h, expected 0",
                     {rsp_valid, rsp_rdata, rsp_err, mip_mtip, mip_msip});
        end
        checks++;
        if (mtime_o !== 64'd0) begin
            errors++;
            $display("FAIL reset_mtime: got %h, expected 0", mtime_o);
        end
        @(negedge clk);
        cpurst_n = 1'b1;
        bus(1'b0, CLINT_MTIMECMP_HI, 32'h0, 4'h0, 32'hFFFF_FFFF, 1'b0);
    endtask

    task automatic test_compare();
        bit seen;
        seen = 0;
        bus(1'b1, CLINT_MTIMECMP_LO, 32'd10, 4'hF, 32'd0, 1'b0);
        bus(1'b1, CLINT_MTIME_LO, 32'd0, 4'hF, 32'd0, 1'b0);
        bus(1'b1, CLINT_MTIMECMP_HI, 32'd0, 4'hF, 32'd0, 1'b0);
        @(negedge clk);
        checks++;
        if (mip_mtip !== 1'b0) begin
            errors++;
            $display("FAIL mtip_early: got %b, expected 0 (mtime=%h)", mip_mtip, mtime_o);
        end
        for (int i = 0; i < 200; i++) begin
            if (mtime_o == 64'd10) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL mtime_reach_10: timeout, mtime=%h expected 10", mtime_o);
            return;
        end
        checks++;
        if (mip_mtip !== 1'b0) begin
            errors++;
            $display("FAIL mtip_lag: got %b on first cycle at 10, expected 0", mip_mtip);
        end
        @(negedge clk);
        checks++;
        if (mip_mtip !== 1'b1) begin
            errors++;
            $display("FAIL mtip_rise: got %b one cycle after mtime=10, expected 1", mip_mtip);
        end
    endtask

    task automatic test_wrap();
        bit seen;
        seen = 0;
        bus(1'b1, CLINT_MTIME_HI, 32'hFFFF_FFFF, 4'hF, 32'd0, 1'b0);
        bus(1'b1, CLINT_MTIME_LO, 32'hFFFF_FFFF, 4'hF, 32'd0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mtime_o != 64'hFFFF_FFFF_FFFF_FFFF) begin
                seen = 1;
                break;
            end
        end
        checks++;
        if (!seen || mtime_o !== 64'd0) begin
            errors++;
            $display("FAIL mtime_wrap: got %h, expected 0", mtime_o);
            return;
        end
        checks++;
        if (mip_mtip !== 1'b1) begin
            errors++;
            $display("FAIL mtip_at_wrap: got %b, expected 1 (lagging all-ones)", mip_mtip);
        end
        @(negedge clk);
        checks++;
        if (mip_mtip !== 1'b0) begin
            errors++;
            $display("FAIL mtip_after_wrap: got %b, expected 0", mip_mtip);
        end
    endtask

    task automatic test_tick_collision();
        logic [63:0] m;
        bit seen;
        seen = 0;
        bus(1'b1, CLINT_MTIME_HI, 32'd0, 4'hF, 32'd0, 1'b0);
        @(negedge clk);
        m = mtime_o;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mtime_o != m) begin
                seen = 1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL tick_sync: mtime stuck at %h", m);
            return;
        end
        // Last tick edge was just before this negedge; next one lands 4 edges later
        repeat (2) @(negedge clk);
        bus(1'b1, CLINT_MTIME_LO, 32'd5, 4'hF, 32'd0, 1'b0);
        checks++;
        if (mtime_o !== 64'd5) begin
            errors++;
            $display("FAIL collide_write: got %h, expected 5", mtime_o);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (mtime_o !== 64'd5) begin
            errors++;
            $display("FAIL collide_hold: got %h, expected 5", mtime_o);
        end
        @(posedge clk);
        #1;
        checks++;
        if (mtime_o !== 64'd6) begin
            errors++;
            $display("FAIL collide_next_tick: got %h, expected 6", mtime_o);
        end
    endtask

    task automatic test_back_to_back();
        clint_rsp_t e;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = CLINT_MTIMECMP_LO;
        req_wstrb = 4'h0;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first_ready: got %b, expected 1", req_ready);
        end
        e.rdata = 32'd10;
        e.err   = 1'b0;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        req_addr = CLINT_MSIP;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (req_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_rdata !== 32'd10 ||
                rsp_err !== 1'b0) begin
                errors++;
                $display("FAIL b2b_stall: cycle %0d ready=%b valid=%b rdata=%h err=%b, %s",
                         i, req_ready, rsp_valid, rsp_rdata, rsp_err,
                         "expected ready=0 valid=1 rdata=0000000a err=0");
            end
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_release: req_ready=%b, expected 1", req_ready);
        end
        e.rdata = 32'd0;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        req_addr = CLINT_MTIMECMP_HI;
        e.rdata  = 32'd0;
        exp_q.push_back(e);
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_no_bubble: ready=%b valid=%b, expected 1 1", req_ready, rsp_valid);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_errors();
        bus(1'b0, 16'h0008, 32'h0, 4'h0, 32'd0, 1'b1);
        bus(1'b0, 16'h4002, 32'h0, 4'h0, 32'd0, 1'b1);
        bus(1'b1, 16'hBFF9, 32'h0, 4'hF, 32'd0, 1'b1);
        bus(1'b0, CLINT_MTIMECMP_LO, 32'h0, 4'h0, 32'd10, 1'b0);
        bus(1'b1, CLINT_MSIP, 32'h1, 4'h1, 32'd0, 1'b0);
        checks++;
        if (mip_msip !== 1'b0) begin
            errors++;
            $display("FAIL msip_lag: got %b at write edge, expected 0", mip_msip);
        end
        @(posedge clk);
        #1;
        checks++;
        if (mip_msip !== 1'b1) begin
            errors++;
            $display("FAIL msip_set: got %b, expected 1", mip_msip);
        end
        bus(1'b1, CLINT_MSIP, 32'h0, 4'h0, 32'd0, 1'b0);
        bus(1'b0, CLINT_MSIP, 32'h0, 4'h0, 32'd1, 1'b0);
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d responses missing, expected 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_compare();
        test_wrap();
        test_tick_collision();
        test_back_to_back();
        test_errors();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
